// File: rtl/time_display_scan.sv
// Scans binary hrs/min/sec as HH.MM.SS onto digits 5..0 of an 8-digit multiplexed 7-segment display.
// Optional macro SEP_BLINK_EN: separators are lit only while the snapshot seconds value is even.
module time_display_scan #(
  parameter int CLK_HZ     = 100_000_000,
  parameter int REFRESH_HZ = 1000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [4:0] hrs,
  input  logic [5:0] min,
  input  logic [5:0] sec,
  output logic [7:0] an,
  output logic [6:0] seg,
  output logic       dp
);

  localparam int DIV = ((CLK_HZ / REFRESH_HZ) > 0) ? (CLK_HZ / REFRESH_HZ) : 1;
  localparam int TW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(DIV - 1);
  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  logic [TW-1:0] tick_reg;
  logic [2:0]    idx_reg;
  logic [4:0]    hrs_reg;
  logic [5:0]    min_reg;
  logic [5:0]    sec_reg;
  logic          en_d_reg;
  logic [7:0]    an_reg;
  logic [6:0]    seg_reg;
  logic          dp_reg;

  logic tick_last;
  logic en_rise;
  logic frame_wrap;
  logic snap_load;

  // Tens/ones by repeated compare-and-subtract; six steps cover any 6-bit value.
  function automatic logic [7:0] bcd_split(input logic [5:0] v);
    logic [3:0] tens;
    logic [5:0] rem;
    tens = 4'd0;
    rem  = v;
    for (int k = 0; k < 6; k++) begin
      if (rem >= 6'd10) begin
        rem  = rem - 6'd10;
        tens = tens + 4'd1;
      end
    end
    return {tens, rem[3:0]};
  endfunction

  function automatic logic [6:0] seg_of(input logic [3:0] d);
    case (d)
      4'd0:    seg_of = 7'b1000000;
      4'd1:    seg_of = 7'b1111001;
      4'd2:    seg_of = 7'b0100100;
      4'd3:    seg_of = 7'b0110000;
      4'd4:    seg_of = 7'b0011001;
      4'd5:    seg_of = 7'b0010010;
      4'd6:    seg_of = 7'b0000010;
      4'd7:    seg_of = 7'b1111000;
      4'd8:    seg_of = 7'b0000000;
      4'd9:    seg_of = 7'b0010000;
      default: seg_of = SEG_BLANK;
    endcase
  endfunction

  assign tick_last  = (tick_reg == TICK_LAST);
  assign en_rise    = en & ~en_d_reg;
  assign frame_wrap = en & tick_last & (idx_reg == 3'd5);
  assign snap_load  = frame_wrap | en_rise;

  // On the enable-rise cycle digit 0 is registered together with the new snapshot,
  // so it reads the live inputs instead of the stale snapshot.
  logic [5:0] field_val [3];
  assign field_val[0] = en_rise ? sec : sec_reg;
  assign field_val[1] = en_rise ? min : min_reg;
  assign field_val[2] = en_rise ? {1'b0, hrs} : {1'b0, hrs_reg};

  logic [6:0] digit_seg [8];
  assign digit_seg[6] = SEG_BLANK;
  assign digit_seg[7] = SEG_BLANK;

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_field
      localparam logic [5:0] LIMIT = (gi == 2) ? 6'd24 : 6'd60;
      logic [7:0] bcd;
      logic       in_range;
      assign bcd      = bcd_split(field_val[gi]);
      assign in_range = (field_val[gi] < LIMIT);
      assign digit_seg[2*gi]   = in_range ? seg_of(bcd[3:0]) : SEG_DASH;
      assign digit_seg[2*gi+1] = in_range ? seg_of(bcd[7:4]) : SEG_DASH;
    end
  endgenerate

  logic [7:0] an_next;
  logic       dp_lit;
  logic       sep_digit;

  always_comb begin
    an_next   = ~(8'd1 << idx_reg);
    sep_digit = (idx_reg == 3'd2) || (idx_reg == 3'd4);
`ifdef SEP_BLINK_EN
    dp_lit    = sep_digit & ~field_val[0][0];
`else
    dp_lit    = sep_digit;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_reg <= '0;
      idx_reg  <= 3'd0;
      hrs_reg  <= 5'd0;
      min_reg  <= 6'd0;
      sec_reg  <= 6'd0;
      // Treated as already enabled so leaving reset with en high keeps the cleared snapshot.
      en_d_reg <= 1'b1;
    end else begin
      en_d_reg <= en;
      if (!en) begin
        tick_reg <= '0;
        idx_reg  <= 3'd0;
      end else if (tick_last) begin
        tick_reg <= '0;
        idx_reg  <= (idx_reg == 3'd5) ? 3'd0 : idx_reg + 3'd1;
      end else begin
        tick_reg <= tick_reg + TW'(1);
      end
      if (snap_load) begin
        hrs_reg <= hrs;
        min_reg <= min;
        sec_reg <= sec;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an_reg  <= 8'hFF;
      seg_reg <= SEG_BLANK;
      dp_reg  <= 1'b1;
    end else if (!en) begin
      an_reg  <= 8'hFF;
      seg_reg <= SEG_BLANK;
      dp_reg  <= 1'b1;
    end else begin
      an_reg  <= an_next;
      seg_reg <= digit_seg[idx_reg];
      dp_reg  <= ~dp_lit;
    end
  end

  assign an  = an_reg;
  assign seg = seg_reg;
  assign dp  = dp_reg;

endmodule

// File: tb/tb_time_display_scan.sv
// Scoreboard bench for time_display_scan: expected digit presentations are queued by the stimulus
// and popped by a monitor each time the display outputs change.
module tb_time_display_scan;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic [4:0] hrs;
  logic [5:0] min;
  logic [5:0] sec;
  logic [7:0] an;
  logic [6:0] seg;
  logic       dp;

  always #5 clk = ~clk;

  time_display_scan #(.CLK_HZ(8000), .REFRESH_HZ(1000)) dut (
    .clk(clk), .rst_n(rst_n), .en(en),
    .hrs(hrs), .min(min), .sec(sec),
    .an(an), .seg(seg), .dp(dp)
  );

  typedef struct {
    logic [7:0] an;
    logic [6:0] seg;
    logic       dp;
    int         dur;   // expected dwell in cycles, 0 = not checked
  } exp_t;

  exp_t       exp_q[$];
  int         checks = 0;
  int         errors = 0;
  logic [6:0] seg_tab [10];

  function automatic logic [6:0] ref_seg(input int v, input int lim, input bit tens);
    int d;
    if (v >= lim) return 7'b0111111;
    d = tens ? (v / 10) : (v % 10);
    return seg_tab[d];
  endfunction

  task automatic push_digit(input int h, input int m, input int s, input int i, input int dur);
    exp_t e;
    int   v;
    int   lim;
    bit   lit;
    v   = (i < 2) ? s : ((i < 4) ? m : h);
    lim = (i < 4) ? 60 : 24;
    e.an  = 8'hFF ^ (8'd1 << i);
    e.seg = ref_seg(v, lim, (i % 2) == 1);
    lit = (i == 2) || (i == 4);
`ifdef SEP_BLINK_EN
    lit = lit && ((s % 2) == 0);
`endif
    e.dp  = !lit;
    e.dur = dur;
    exp_q.push_back(e);
  endtask

  task automatic push_frame(input int h, input int m, input int s);
    for (int i = 0; i < 6; i++) push_digit(h, m, s, i, 8);
  endtask

  task automatic push_blank();
    exp_t e;
    e = '{8'hFF, 7'h7F, 1'b1, 0};
    exp_q.push_back(e);
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic set_time(input int h, input int m, input int s);
    hrs = 5'(h);
    min = 6'(m);
    sec = 6'(s);
  endtask

  // Monitor: a change of {an,seg,dp} is a new digit presentation.
  initial begin
    logic [15:0] prev;
    int          cnt;
    int          cur_dur;
    int          txn;
    bit          have;
    exp_t        e;
    prev = 'x; cnt = 0; cur_dur = 0; txn = 0; have = 1'b0;
    forever begin
      @(negedge clk);
      if ({an, seg, dp} !== prev) begin
        if (have && cur_dur != 0) begin
          checks++;
          if (cnt != cur_dur) begin
            errors++;
            $display("FAIL dwell: an=%h held %0d cycles, required %0d", prev[15:8], cnt, cur_dur);
          end
        end
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output: an=%h seg=%b dp=%b with nothing expected", an, seg, dp);
          cur_dur = 0;
        end else begin
          e = exp_q.pop_front();
          checks++;
          txn++;
          if ({an, seg, dp} !== {e.an, e.seg, e.dp}) begin
            errors++;
            $display("FAIL digit txn %0d: got an=%h seg=%b dp=%b, required an=%h seg=%b dp=%b",
                     txn, an, seg, dp, e.an, e.seg, e.dp);
          end else begin
            $display("txn %0d: an=%h seg=%b dp=%b ok", txn, an, seg, dp);
          end
          cur_dur = e.dur;
        end
        prev = {an, seg, dp};
        cnt  = 1;
        have = 1'b1;
      end else begin
        cnt++;
      end
    end
  end

  initial begin
    int h;
    int m;
    int s;
    int off;
    seg_tab = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
    rst_n = 1'b0;
    en    = 1'b0;
    set_time(12, 34, 56);
    push_blank();
    tick(3);
    rst_n = 1'b1;
    tick(2);

    // Enable rise snapshots 12:34:56; a mid-frame seconds change shows only next frame.
    en = 1'b1;
    push_frame(12, 34, 56);
    tick(26);
    sec = 6'd57;
    push_frame(12, 34, 57);
    tick(40);
    set_time(25, 60, 5);
    push_frame(25, 60, 5);
    tick(34);
    set_time(3, 7, 9);

    // Disable during idx2 of the 03.07.09 frame.
    push_digit(3, 7, 9, 0, 8);
    push_digit(3, 7, 9, 1, 8);
    push_digit(3, 7, 9, 2, 0);
    push_blank();
    tick(62);
    en = 1'b0;
    tick(5);
    set_time(21, 45, 18);
    en = 1'b1;
    push_frame(21, 45, 18);
    for (int i = 0; i < 4; i++) push_digit(21, 45, 18, i, 8);
    push_digit(21, 45, 18, 4, 0);
    push_blank();

    // Reset asserted during idx4 of the second frame, away from any clock edge.
    tick(83);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({an, seg, dp} !== {8'hFF, 7'h7F, 1'b1}) begin
      errors++;
      $display("FAIL async_reset: got an=%h seg=%b dp=%b, required an=ff seg=1111111 dp=1", an, seg, dp);
    end
    tick(3);
    rst_n = 1'b1;
    push_frame(0, 0, 0);

    // Random fields (including out-of-range values) changed at a random point each frame.
    for (int k = 0; k < 12; k++) begin
      off = $urandom_range(1, 47);
      tick(off);
      h = $urandom_range(0, 31);
      m = $urandom_range(0, 63);
      s = $urandom_range(0, 63);
      set_time(h, m, s);
      push_frame(h, m, s);
      tick(48 - off);
    end
    tick(48);
    en = 1'b0;
    push_blank();

    for (int w = 0; w < 200 && exp_q.size() != 0; w++) tick(1);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expected presentations never seen, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
